// File: rtl/pwm_from_count.sv
// PWM generator driven by an external free-running 4-bit count. It detects 15->0 wraps,
// applies duty changes only at period boundaries, and flags breaks in the count sequence.
module pwm_from_count (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] count_in,
  input  logic [3:0] duty_in,
  input  logic       duty_load,
  output logic       pwm_out,
  output logic       period_tick,
  output logic [3:0] duty_active,
  output logic [7:0] period_cnt,
  output logic       seq_err,
  output logic [3:0] err_cnt
);

  logic [3:0] r_prev;
  logic       r_valid;
  logic [3:0] r_pending;
  logic       r_pending_valid;

  logic [3:0] w_prev_inc;
  logic       w_wrap_now;
  logic       w_seq_bad;
  logic [3:0] w_duty_eff;

  assign w_prev_inc = r_prev + 4'd1;
  assign w_wrap_now = r_valid && (r_prev == 4'd15) && (count_in == 4'd0);
  assign w_seq_bad  = r_valid && (count_in != w_prev_inc);

  // Duty in force after this edge: a load coinciding with the wrap beats the pending value
  always_comb begin
    w_duty_eff = duty_active;
    if (w_wrap_now) begin
      if (duty_load) begin
        w_duty_eff = duty_in;
      end else if (r_pending_valid) begin
        w_duty_eff = r_pending;
      end else begin
        w_duty_eff = duty_active;
      end
    end else begin
      w_duty_eff = duty_active;
    end
  end

  // Count tracking and pending-duty bookkeeping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev          <= 4'd0;
      r_valid         <= 1'b0;
      r_pending       <= 4'd0;
      r_pending_valid <= 1'b0;
    end else begin
      r_prev  <= count_in;
      r_valid <= 1'b1;
      if (w_wrap_now) begin
        r_pending_valid <= 1'b0;
      end else if (duty_load) begin
        r_pending       <= duty_in;
        r_pending_valid <= 1'b1;
      end
    end
  end

  // Registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_out     <= 1'b0;
      period_tick <= 1'b0;
      duty_active <= 4'd0;
      period_cnt  <= 8'd0;
      seq_err     <= 1'b0;
      err_cnt     <= 4'd0;
    end else begin
      duty_active <= w_duty_eff;
      pwm_out     <= (count_in < w_duty_eff);
      period_tick <= w_wrap_now;
      seq_err     <= w_seq_bad;
      if (w_wrap_now) begin
        period_cnt <= period_cnt + 8'd1;
      end
      if (w_seq_bad && (err_cnt != 4'd15)) begin
        err_cnt <= err_cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_from_count.sv
// Directed and randomized checks of pwm_from_count against a behavioural model
// that keeps requested duties in a queue and tracks periods and errors arithmetically.
module tb_pwm_from_count;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] count_in;
  logic [3:0] duty_in;
  logic       duty_load;
  logic       pwm_out;
  logic       period_tick;
  logic [3:0] duty_active;
  logic [7:0] period_cnt;
  logic       seq_err;
  logic [3:0] err_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit m_has_prev;
  int m_prev;
  int m_duty;
  int m_pcnt;
  int m_ecnt;
  bit m_pwm;
  bit m_tick;
  bit m_err;
  int m_q[$];

  always #5 clk = ~clk;

  pwm_from_count dut (
    .clk(clk), .reset(reset), .count_in(count_in), .duty_in(duty_in),
    .duty_load(duty_load), .pwm_out(pwm_out), .period_tick(period_tick),
    .duty_active(duty_active), .period_cnt(period_cnt), .seq_err(seq_err),
    .err_cnt(err_cnt)
  );

  task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic check_all();
    chk("pwm_out", 8'(pwm_out), 8'(m_pwm));
    chk("period_tick", 8'(period_tick), 8'(m_tick));
    chk("duty_active", 8'(duty_active), 8'(m_duty));
    chk("period_cnt", period_cnt, 8'(m_pcnt));
    chk("seq_err", 8'(seq_err), 8'(m_err));
    chk("err_cnt", 8'(err_cnt), 8'(m_ecnt));
  endtask

  task automatic model_reset();
    m_has_prev = 1'b0;
    m_prev = 0;
    m_duty = 0;
    m_pcnt = 0;
    m_ecnt = 0;
    m_pwm  = 1'b0;
    m_tick = 1'b0;
    m_err  = 1'b0;
    m_q.delete();
  endtask

  task automatic step(input int c, input bit ld, input int d);
    bit wrap;
    count_in  = 4'(c);
    duty_load = ld;
    duty_in   = 4'(d);
    @(posedge clk);
    #1;
    wrap  = m_has_prev && (m_prev == 15) && (c == 0);
    m_err = m_has_prev && (c != (m_prev + 1) % 16);
    if (wrap) begin
      if (ld) m_duty = d;
      else if (m_q.size() > 0) m_duty = m_q[$];
      m_q.delete();
    end else if (ld) begin
      m_q.push_back(d);
    end
    m_tick = wrap;
    if (wrap) m_pcnt = (m_pcnt + 1) % 256;
    if (m_err && m_ecnt < 15) m_ecnt++;
    m_pwm = (c < m_duty);
    m_prev = c;
    m_has_prev = 1'b1;
    check_all();
  endtask

  task automatic run_period(input int ld_at, input int din);
    for (int c = 0; c < 16; c++) step(c, c == ld_at, din);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #2;
    model_reset();
    check_all();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    count_in = 4'd0;
    duty_in = 4'd0;
    duty_load = 1'b0;
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    reset = 1'b0;

    // Load 5 at count 3; takes effect only at the wrap
    run_period(3, 5);
    chk("duty_before_wrap", 8'(duty_active), 8'd0);
    run_period(-1, 0);
    chk("duty_after_wrap", 8'(duty_active), 8'd5);

    // Pending 4, then a load of 9 coinciding with the wrap
    for (int c = 1; c < 16; c++) step(c, c == 6, 4);
    step(0, 1'b1, 9);
    chk("duty_wrap_load", 8'(duty_active), 8'd9);
    for (int c = 1; c < 16; c++) step(c, 1'b0, 0);
    step(0, 1'b0, 0);
    chk("pending_cleared", 8'(duty_active), 8'd9);

    // Two loads in one period, last wins
    for (int c = 1; c < 16; c++) step(c, (c == 2) || (c == 9), (c == 2) ? 7 : 2);
    step(0, 1'b0, 0);
    chk("duty_two_loads", 8'(duty_active), 8'd2);

    // Duty boundaries 0 and 15
    for (int c = 1; c < 16; c++) step(c, c == 5, 0);
    run_period(7, 15);
    run_period(-1, 0);
    step(0, 1'b0, 0);
    chk("duty15_at_0", 8'(pwm_out), 8'd1);

    // Sequence errors and saturation
    do_reset();
    step(3, 1'b0, 0);
    step(4, 1'b0, 0);
    step(4, 1'b0, 0);
    step(6, 1'b0, 0);
    step(0, 1'b0, 0);
    chk("err_cnt_seq", 8'(err_cnt), 8'd3);
    for (int i = 0; i < 20; i++) step(0, 1'b0, 0);
    chk("err_cnt_sat", 8'(err_cnt), 8'd15);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      int c;
      if ($urandom_range(7, 0) != 0) c = (m_prev + 1) % 16;
      else c = int'($urandom_range(15, 0));
      step(c, $urandom_range(3, 0) == 0, int'($urandom_range(15, 0)));
    end

    // period_cnt rollover
    do_reset();
    for (int p = 0; p < 256; p++) run_period(-1, 0);
    step(0, 1'b0, 0);
    chk("period_cnt_256", period_cnt, 8'd0);
    for (int c = 1; c < 16; c++) step(c, 1'b0, 0);
    step(0, 1'b0, 0);
    chk("period_cnt_257", period_cnt, 8'd1);

    // Asynchronous reset mid-period with pwm high and a duty pending
    for (int c = 1; c < 16; c++) step(c, 1'b0, 0);
    step(0, 1'b1, 10);
    step(1, 1'b0, 0);
    step(2, 1'b1, 3);
    step(3, 1'b0, 0);
    step(4, 1'b0, 0);
    chk("pwm_high_pre_reset", 8'(pwm_out), 8'd1);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    reset = 1'b0;
    run_period(-1, 0);
    step(0, 1'b0, 0);
    chk("duty_after_reset_wrap", 8'(duty_active), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_from_count.md
PWM_FROM_COUNT -- requirements
Module: pwm_from_count

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-high; ports are named clk and reset.
REQ-002 The block SHALL have port clk, input, 1 bit: rising-edge clock for all state.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous active-high reset.
REQ-004 The block SHALL have port count_in, input, 4 bits: free-running count from the upstream 4-bit up counter, expected to advance by 1 each clk, mod 16.
REQ-005 The block SHALL have port duty_in, input, 4 bits: requested duty threshold.
REQ-006 The block SHALL have port duty_load, input, 1 bit: single-cycle strobe that captures duty_in.
REQ-007 The block SHALL have port pwm_out, output, 1 bit: registered PWM output.
REQ-008 The block SHALL have port period_tick, output, 1 bit: one-cycle pulse per detected 15->0 wrap.
REQ-009 The block SHALL have port duty_active, output, 4 bits: threshold currently in force.
REQ-010 The block SHALL have port period_cnt, output, 8 bits: number of wraps detected, mod 256.
REQ-011 The block SHALL have port seq_err, output, 1 bit: one-cycle pulse on a count-sequence violation.
REQ-012 The block SHALL have port err_cnt, output, 4 bits: saturating count of violations.

Function
REQ-013 Internal state SHALL be: prev (4b, last sampled count_in), valid (1b), pending (4b), pending_valid (1b), and the registered outputs.
REQ-014 Every output SHALL be registered, with 1-cycle latency from the count_in sample that causes it.
REQ-015 At each edge, wrap_now SHALL be valid AND prev==15 AND count_in==0.
REQ-016 At each edge, prev SHALL load count_in and valid SHALL set to 1.
REQ-017 When duty_load=1 and wrap_now=0, the block SHALL set pending to duty_in and pending_valid to 1, and duty_active SHALL stay unchanged.
REQ-018 When wrap_now=1, duty_active SHALL load the first of the following that applies: duty_in if duty_load=1; pending if pending_valid=1; otherwise its current value. pending_valid SHALL then clear.
REQ-019 A duty_load that coincides with a wrap SHALL be applied at that wrap and SHALL NOT be left pending; a second duty_load before a wrap SHALL overwrite pending (last write wins).
REQ-020 duty_eff SHALL be the duty_active value that results from REQ-018 at that edge; pwm_out SHALL load (count_in < duty_eff), an unsigned 4-bit compare.
REQ-021 duty_eff=0 SHALL give pwm_out constantly 0; duty_eff=15 SHALL give pwm_out high for counts 0..14 and low for 15.
REQ-022 period_tick SHALL load wrap_now, and period_cnt SHALL increment by 1 on wrap_now, wrapping 255->0.
REQ-023 seq_err SHALL load (valid AND count_in != prev+1 mod 16); a hold, skip or upstream reset to 0 from a value other than 15 all count as errors.
REQ-024 err_cnt SHALL increment on each seq_err condition and saturate at 15.
REQ-025 The first sample after reset (valid=0) SHALL NOT raise seq_err or period_tick.

Reset
REQ-026 While reset=1, the block SHALL hold pwm_out=0, period_tick=0, seq_err=0, duty_active=0, period_cnt=0, err_cnt=0, prev=0, valid=0, pending=0 and pending_valid=0, independent of clk.
REQ-027 Reset asserted mid-period SHALL discard any pending duty.
REQ-028 After reset deasserts, operation SHALL resume from the next rising clk edge.

Verification
REQ-029 Reset, then count_in 0..15 repeating with duty_load=1 and duty_in=5 at count 3 -> duty_active stays 0 and pwm_out stays 0 until the 15->0 wrap; there, duty_active=5 and pwm_out is high for counts 0..4 of each following period (1-cycle lag), and period_tick pulses once per period.
REQ-030 duty_load with duty_in=9 on the same edge as count_in 15->0, while pending=4 is valid -> duty_active=9, pending_valid=0, and pwm_out is high for counts 0..8.
REQ-031 Two loads in one period (7, then 2) -> at the next wrap duty_active=2.
REQ-032 count_in sequence 3,4,4,6,0 -> three seq_err pulses (for 4->4, 4->6 and 6->0), err_cnt=3, no period_tick; after 20 violations err_cnt stays at 15.
REQ-033 Run 256 full periods -> period_cnt returns to 0; 257 periods -> period_cnt=1.
REQ-034 Assert reset asynchronously between edges while pwm_out=1 and pending_valid=1 -> all outputs are 0 immediately, and the first wrap after release leaves duty_active=0.
